// File: rtl/bcd_conv_arbiter_if.sv
// Request/result bundle between the two display-path requesters and the shared
// binary-to-BCD engine.
interface bcd_conv_arbiter_if #(
  parameter int WIDTH  = 32,
  parameter int DIGITS = 10
);
  // Handshake: req[i] is a level held by requester i until it sees done with
  // done_id == i. gnt is the one-hot acknowledgement from the grant edge through
  // the done cycle. bin0/bin1 are sampled only on the grant edge. bcd_out and
  // done_id are valid from the done cycle and hold until the next done.
  logic [1:0]          req;
  logic [WIDTH-1:0]    bin0;
  logic [WIDTH-1:0]    bin1;
  logic [1:0]          gnt;
  logic                busy;
  logic                done;
  logic                done_id;
  logic [4*DIGITS-1:0] bcd_out;

  modport master (
    output req, bin0, bin1,
    input  gnt, busy, done, done_id, bcd_out
  );

  modport slave (
    input  req, bin0, bin1,
    output gnt, busy, done, done_id, bcd_out
  );
endinterface

// File: rtl/bcd_conv_arbiter.sv
// Time-shared double-dabble binary-to-BCD converter serving two requesters
// through a round-robin arbiter; one shift per clock.
module bcd_conv_arbiter #(
  parameter int WIDTH  = 32,
  parameter int DIGITS = 10
) (
  input  logic                clk,
  input  logic                rst_n,
  bcd_conv_arbiter_if.slave   bus,
  output logic [1:0]          dbg_state
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int BCD_W = 4 * DIGITS;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               last_q, last_d;
  logic [1:0]         gnt_q, gnt_d;
  logic [WIDTH-1:0]   sr_q, sr_d;
  logic [BCD_W-1:0]   acc_q, acc_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic               done_id_q, done_id_d;

  logic               sel;
  logic [BCD_W-1:0]   adj;
  logic [BCD_W+WIDTH-1:0] cat;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      last_q    <= 1'b1;
      gnt_q     <= 2'b00;
      sr_q      <= '0;
      acc_q     <= '0;
      bcd_q     <= '0;
      done_id_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      last_q    <= last_d;
      gnt_q     <= gnt_d;
      sr_q      <= sr_d;
      acc_q     <= acc_d;
      bcd_q     <= bcd_d;
      done_id_q <= done_id_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    last_d    = last_q;
    gnt_d     = gnt_q;
    sr_d      = sr_q;
    acc_d     = acc_q;
    bcd_d     = bcd_q;
    done_id_d = done_id_q;
    sel       = 1'b0;

    // Add-3 on every digit >= 5 before the shift, so each digit stays < 10 after it.
    adj = acc_q;
    for (int k = 0; k < DIGITS; k++) begin
      if (acc_q[4*k +: 4] >= 4'd5) adj[4*k +: 4] = acc_q[4*k +: 4] + 4'd3;
    end
    cat = {adj, sr_q} << 1;

    case (state_q)
      S_IDLE: begin
        if (|bus.req) begin
          sel     = (bus.req == 2'b11) ? ~last_q : bus.req[1];
          gnt_d   = sel ? 2'b10 : 2'b01;
          last_d  = sel;
          sr_d    = sel ? bus.bin1 : bus.bin0;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        acc_d = cat[BCD_W+WIDTH-1 -: BCD_W];
        sr_d  = cat[WIDTH-1:0];
        cnt_d = cnt_q + CNT_W'(1);
        // last_q already names the granted requester for this conversion.
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          bcd_d     = cat[BCD_W+WIDTH-1 -: BCD_W];
          done_id_d = last_q;
          state_d   = S_DONE;
        end
      end
      S_DONE: begin
        gnt_d   = 2'b00;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.gnt     = gnt_q;
  assign bus.busy    = (state_q != S_IDLE);
  assign bus.done    = (state_q == S_DONE);
  assign bus.done_id = done_id_q;
  assign bus.bcd_out = bcd_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_bcd_conv_arbiter.sv
// Directed bench for bcd_conv_arbiter: table of single-requester conversions
// plus hand-written round-robin, req-drop and mid-conversion reset sequences.
module tb_bcd_conv_arbiter;

  localparam int WIDTH  = 32;
  localparam int DIGITS = 10;
  localparam int BW     = 4 * DIGITS;

  logic       clk;
  logic       rst_n;
  logic [1:0] dbg_state;

  bcd_conv_arbiter_if #(.WIDTH(WIDTH), .DIGITS(DIGITS)) bus ();

  bcd_conv_arbiter #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [BW-1:0] exp_q[$];

  typedef struct {
    logic [1:0]       req;
    logic [WIDTH-1:0] bin;
    logic [BW-1:0]    exp_bcd;
    logic             exp_id;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic wait_done(output int cyc, output bit seen);
    cyc  = 0;
    seen = 0;
    while (!seen && cyc < 200) begin
      @(posedge clk);
      @(negedge clk);
      cyc++;
      if (bus.done === 1'b1) seen = 1;
    end
  endtask

  task automatic run_conv(input logic [1:0] r, input logic [WIDTH-1:0] b,
                          input logic [BW-1:0] eb, input logic eid);
    int cyc;
    bit seen;
    bit gnt_ok;
    logic [BW-1:0] e;
    exp_q.push_back(eb);
    @(negedge clk);
    if (r[0]) begin bus.bin0 = b; bus.bin1 = $urandom; end
    else      begin bus.bin1 = b; bus.bin0 = $urandom; end
    bus.req = r;
    @(posedge clk);
    @(negedge clk);
    bus.req = 2'b00;
    check("grant_onehot", 64'(bus.gnt), 64'(r));
    check("busy_after_grant", 64'(bus.busy), 64'd1);
    cyc = 0; seen = 0; gnt_ok = 1;
    while (!seen && cyc < 100) begin
      @(posedge clk);
      @(negedge clk);
      cyc++;
      if (bus.gnt !== r) gnt_ok = 0;
      if (bus.done === 1'b1) seen = 1;
    end
    e = exp_q.pop_front();
    check("done_seen", 64'(seen), 64'd1);
    check("latency", 64'(cyc), 64'd32);
    check("gnt_held", 64'(gnt_ok), 64'd1);
    check("done_id", 64'(bus.done_id), 64'(eid));
    check("bcd_out", 64'(bus.bcd_out), 64'(e));
    @(posedge clk);
    @(negedge clk);
    check("done_fall", {60'd0, bus.done, bus.busy, bus.gnt}, 64'd0);
    check("bcd_hold", 64'(bus.bcd_out), 64'(e));
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int cyc;
    bit seen;
    int ndone;

    vecs[0] = '{2'b01, 32'd1234,       40'h0000001234, 1'b0};
    vecs[1] = '{2'b10, 32'hFFFFFFFF,   40'h4294967295, 1'b1};
    vecs[2] = '{2'b01, 32'd0,          40'h0000000000, 1'b0};
    vecs[3] = '{2'b10, 32'd10,         40'h0000000010, 1'b1};
    vecs[4] = '{2'b01, 32'd99999999,   40'h0099999999, 1'b0};
    vecs[5] = '{2'b10, 32'd100000,     40'h0000100000, 1'b1};

    rst_n    = 1'b0;
    bus.req  = 2'b00;
    bus.bin0 = '0;
    bus.bin1 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_gnt", 64'(bus.gnt), 64'd0);
    check("rst_flags", {61'd0, bus.busy, bus.done, bus.done_id}, 64'd0);
    check("rst_bcd", 64'(bus.bcd_out), 64'd0);
    check("rst_state", 64'(dbg_state), 64'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++)
      run_conv(vecs[i].req, vecs[i].bin, vecs[i].exp_bcd, vecs[i].exp_id);

    // Round robin after reset with both requesters held.
    apply_reset();
    bus.bin0 = 32'd7;
    bus.bin1 = 32'd59;
    bus.req  = 2'b11;
    wait_done(cyc, seen);
    check("rr0_seen", 64'(seen), 64'd1);
    check("rr0_lat", 64'(cyc), 64'd33);
    check("rr0_id", 64'(bus.done_id), 64'd0);
    check("rr0_bcd", 64'(bus.bcd_out), 64'h7);
    wait_done(cyc, seen);
    check("rr1_lat", 64'(cyc), 64'd34);
    check("rr1_id", 64'(bus.done_id), 64'd1);
    check("rr1_bcd", 64'(bus.bcd_out), 64'h59);
    wait_done(cyc, seen);
    check("rr2_id", 64'(bus.done_id), 64'd0);
    check("rr2_bcd", 64'(bus.bcd_out), 64'h7);
    wait_done(cyc, seen);
    check("rr3_id", 64'(bus.done_id), 64'd1);
    bus.req = 2'b00;
    repeat (3) @(negedge clk);

    // Drop req and change operand mid-conversion.
    bus.bin0 = 32'd999;
    bus.req  = 2'b01;
    @(posedge clk);
    repeat (3) @(posedge clk);
    @(negedge clk);
    bus.req  = 2'b00;
    bus.bin0 = 32'd5;
    wait_done(cyc, seen);
    check("drop_seen", 64'(seen), 64'd1);
    check("drop_lat", 64'(cyc), 64'd29);
    check("drop_bcd", 64'(bus.bcd_out), 64'h999);
    check("drop_id", 64'(bus.done_id), 64'd0);
    repeat (2) @(negedge clk);

    // Asynchronous reset in the middle of a conversion.
    bus.bin1 = 32'd100000;
    bus.req  = 2'b10;
    @(posedge clk);
    repeat (10) @(posedge clk);
    @(negedge clk);
    bus.req = 2'b00;
    check("pre_rst_busy", 64'(bus.busy), 64'd1);
    rst_n = 1'b0;
    #1;
    check("arst_gnt", 64'(bus.gnt), 64'd0);
    check("arst_flags", {61'd0, bus.busy, bus.done, bus.done_id}, 64'd0);
    check("arst_bcd", 64'(bus.bcd_out), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) ndone++;
    end
    check("no_done_after_abort", 64'(ndone), 64'd0);
    bus.bin0 = 32'd7;
    bus.bin1 = 32'd59;
    bus.req  = 2'b11;
    wait_done(cyc, seen);
    bus.req = 2'b00;
    check("post_rst_seen", 64'(seen), 64'd1);
    check("post_rst_id", 64'(bus.done_id), 64'd0);
    check("post_rst_bcd", 64'(bus.bcd_out), 64'h7);
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
